fc_argmax: RTL and testbench
============================

Name: fc_argmax

Overview:
Downstream consumer of the BNN core's fully-connected result stream. It collects the NUM_CLASS signed class scores of one frame, one per result_tvalid beat, and tracks the running maximum. It then presents the winning class index and score on a ready/valid output for the host/AXI wrapper. It also flags malformed frames, such as short or over-long beat sequences.

Parameters:
NUM_CLASS, 10, number of FC outputs (scores) per frame
DATA_W, 32, score width, signed two's complement
IDX_W, 4, class index width; must satisfy 2^IDX_W >= NUM_CLASS

Ports:
clk  input  1  system clock
rstn  input  1  synchronous active-low reset
start_cnn  input  1  frame start pulse, same signal that starts the core
result_tvalid  input  1  score beat valid; no back-pressure, core never stalls
result_tdata  input  DATA_W  signed score; beat k carries class k
cnn_done  input  1  core end-of-inference pulse
class_tvalid  output  1  winning class available
class_tready  input  1  downstream accepts class result
class_tdata  output  IDX_W  winning class index
class_score  output  DATA_W  winning score, signed
frame_err  output  1  sticky malformed-frame flag
beat_cnt  output  IDX_W  beats accepted in the current frame

Behaviour:
- Reset, sampled on the clk edge when rstn=0: state=IDLE, class_tvalid=0, class_tdata=0, class_score=0, frame_err=0, beat_cnt=0, and the internal max register = most-negative DATA_W value.
- FSM states: IDLE, COLLECT, OUT.
- IDLE:
  - start_cnn: clear beat_cnt, max and frame_err; go to COLLECT.
  - A result_tvalid beat without a prior start_cnn implicitly starts a frame. It is taken as class 0, and the FSM goes to COLLECT with beat_cnt=1.
- COLLECT, per valid beat:
  - Signed compare result_tdata > max (strict), evaluated on the full DATA_W.
  - If true, max<=result_tdata and idx<=beat_cnt.
  - beat_cnt increments.
  - Beat 0 always loads max/idx.
  - Ties keep the lowest index.
- Completion: when the beat with beat_cnt==NUM_CLASS-1 is accepted, the FSM goes to OUT.
  - class_tvalid=1 on the next cycle, so latency is 1 clk from the last beat.
  - class_tdata/class_score carry the final idx/max, including the update from that last beat.
- OUT:
  - Outputs are held stable while class_tvalid=1 && class_tready=0.
  - On class_tvalid && class_tready: class_tvalid<=0 and the FSM returns to IDLE. class_tdata/class_score keep their last value.
- Short frame: cnn_done in COLLECT with beat_cnt<NUM_CLASS sets frame_err=1. No output is produced, and the FSM goes to IDLE.
  - A last beat and cnn_done in the same cycle is a legal completion.
- Extra beats: result_tvalid in OUT sets frame_err=1. The beat is dropped and the outputs are unchanged.
- cnn_done in IDLE/OUT is ignored.
- start_cnn has priority in any state.
  - It aborts the frame, drops class_tvalid, clears frame_err, beat_cnt and max, and enters COLLECT.
  - A result_tvalid beat in the same cycle as start_cnn is accepted as class 0 of the new frame (beat_cnt=1).
- frame_err is sticky. It is cleared only by start_cnn or reset.
- beat_cnt saturates at NUM_CLASS and never wraps.
- Reset mid-frame returns everything to reset values on the next edge; no partial output is produced.

Test Plan:
- start_cnn, then 10 beats with scores -5,3,17,-2,0,9,17,-100,4,1 -> class_tvalid 1 clk after beat 9, class_tdata=2 (tie with index 6 keeps the lowest), class_score=17, frame_err=0.
- All-negative scores -10..-1 in index order, class_tready held 0 for 5 cycles, then 1 -> class_tdata=9, class_score=-1. Outputs stay stable while stalled; class_tvalid drops the cycle after the handshake.
- Score 0x80000000 for class 0 and 0x7FFFFFFF for class 3 -> class_tdata=3, class_score=2147483647. This proves the compare is signed.
- Short frame: 6 beats, then cnn_done -> no class_tvalid, frame_err=1, beat_cnt=6. The next start_cnn clears frame_err=0.
- Over-long frame: 11 back-to-back beats with class_tready=0 -> result from the first 10 beats only, frame_err=1 from the 11th beat.
- Abort and reset:
  - start_cnn during beat 4 of a frame, then 10 fresh beats -> the result reflects only the new frame.
  - rstn=0 for 1 cycle during OUT -> class_tvalid=0 and all outputs at reset values next cycle.

Source files
------------

// File: rtl/fc_argmax_if.sv
// Stream bundle between the BNN core, the argmax block and the host wrapper.
// The slave modport is the argmax side. The master modport is the core/host side.
interface fc_argmax_if #(
  parameter int DATA_W = 32,
  parameter int IDX_W  = 4
);
  logic              start_cnn;
  logic              cnn_done;
  logic              result_tvalid;
  logic [DATA_W-1:0] result_tdata;
  logic              class_tvalid;
  logic              class_tready;
  logic [IDX_W-1:0]  class_tdata;
  logic [DATA_W-1:0] class_score;
  logic              frame_err;
  logic [IDX_W-1:0]  beat_cnt;

  modport slave (
    input  start_cnn, cnn_done, result_tvalid, result_tdata, class_tready,
    output class_tvalid, class_tdata, class_score, frame_err, beat_cnt
  );

  modport master (
    output start_cnn, cnn_done, result_tvalid, result_tdata, class_tready,
    input  class_tvalid, class_tdata, class_score, frame_err, beat_cnt
  );
endinterface

// File: rtl/fc_argmax.sv
// Running signed argmax over the per-frame FC score stream.
// The winning class index and score are presented on a ready/valid output, and malformed frames are flagged.
module fc_argmax #(
  parameter int NUM_CLASS = 10,
  parameter int DATA_W    = 32,
  parameter int IDX_W     = 4
) (
  input  logic        clk,
  input  logic        rstn,
  fc_argmax_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    OUT     = 2'd2
  } state_t;

  localparam logic [DATA_W-1:0] MOST_NEG = {1'b1, {(DATA_W-1){1'b0}}};
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NUM_CLASS - 1);
  localparam logic [IDX_W-1:0]  SAT_CNT  = IDX_W'(NUM_CLASS);

  state_t            state_q, state_d;
  logic [IDX_W-1:0]  beat_cnt_q, beat_cnt_d;
  logic [DATA_W-1:0] max_q, max_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              class_tvalid_q, class_tvalid_d;
  logic [IDX_W-1:0]  class_tdata_q, class_tdata_d;
  logic [DATA_W-1:0] class_score_q, class_score_d;
  logic              frame_err_q, frame_err_d;

  logic              fresh_s, accept_s, load_s, last_s, handshake_s;
  logic [IDX_W-1:0]  cnt_base_s, new_idx_s;
  logic [DATA_W-1:0] max_base_s, new_max_s;

  // A beat starting a frame (explicit or implicit) compares against a cleared max/count
  always_comb begin
    fresh_s     = bus.start_cnn || (state_q == IDLE);
    cnt_base_s  = fresh_s ? {IDX_W{1'b0}} : beat_cnt_q;
    max_base_s  = fresh_s ? MOST_NEG : max_q;
    accept_s    = bus.result_tvalid && (bus.start_cnn || (state_q != OUT));
    load_s      = (cnt_base_s == {IDX_W{1'b0}}) ||
                  ($signed(bus.result_tdata) > $signed(max_base_s));
    last_s      = accept_s && (cnt_base_s == LAST_IDX);
    new_idx_s   = load_s ? cnt_base_s : idx_q;
    new_max_s   = load_s ? bus.result_tdata : max_base_s;
    handshake_s = class_tvalid_q && bus.class_tready;
  end

  // State register plus all datapath/output registers
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q        <= IDLE;
      beat_cnt_q     <= {IDX_W{1'b0}};
      max_q          <= MOST_NEG;
      idx_q          <= {IDX_W{1'b0}};
      class_tvalid_q <= 1'b0;
      class_tdata_q  <= {IDX_W{1'b0}};
      class_score_q  <= {DATA_W{1'b0}};
      frame_err_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      beat_cnt_q     <= beat_cnt_d;
      max_q          <= max_d;
      idx_q          <= idx_d;
      class_tvalid_q <= class_tvalid_d;
      class_tdata_q  <= class_tdata_d;
      class_score_q  <= class_score_d;
      frame_err_q    <= frame_err_d;
    end
  end

  // Next-state logic; start_cnn overrides whatever the FSM was doing
  always_comb begin
    state_d = state_q;
    if (bus.start_cnn) begin
      state_d = last_s ? OUT : COLLECT;
    end else begin
      case (state_q)
        IDLE:    state_d = accept_s ? (last_s ? OUT : COLLECT) : IDLE;
        COLLECT: state_d = last_s ? OUT : (bus.cnn_done ? IDLE : COLLECT);
        OUT:     state_d = handshake_s ? IDLE : OUT;
        default: state_d = IDLE;
      endcase
    end
  end

  // Datapath and output next values
  always_comb begin
    beat_cnt_d     = beat_cnt_q;
    max_d          = max_q;
    idx_d          = idx_q;
    class_tvalid_d = class_tvalid_q;
    class_tdata_d  = class_tdata_q;
    class_score_d  = class_score_q;
    frame_err_d    = frame_err_q;

    if (bus.start_cnn) begin
      beat_cnt_d     = {IDX_W{1'b0}};
      max_d          = MOST_NEG;
      class_tvalid_d = 1'b0;
      frame_err_d    = 1'b0;
    end else begin
      case (state_q)
        IDLE:    frame_err_d = frame_err_q;
        COLLECT: frame_err_d = frame_err_q || (bus.cnn_done && !last_s);
        OUT: begin
          frame_err_d    = frame_err_q || bus.result_tvalid;
          class_tvalid_d = handshake_s ? 1'b0 : class_tvalid_q;
        end
        default: frame_err_d = frame_err_q;
      endcase
    end

    if (accept_s) begin
      beat_cnt_d = (cnt_base_s == SAT_CNT) ? SAT_CNT : cnt_base_s + {{(IDX_W-1){1'b0}}, 1'b1};
      max_d      = new_max_s;
      idx_d      = new_idx_s;
    end else begin
      idx_d      = idx_q;
    end

    // Result includes the final beat's own update
    if (last_s) begin
      class_tvalid_d = 1'b1;
      class_tdata_d  = new_idx_s;
      class_score_d  = new_max_s;
    end else begin
      class_tdata_d  = class_tdata_q;
    end
  end

  assign bus.class_tvalid = class_tvalid_q;
  assign bus.class_tdata  = class_tdata_q;
  assign bus.class_score  = class_score_q;
  assign bus.frame_err    = frame_err_q;
  assign bus.beat_cnt     = beat_cnt_q;

endmodule

// File: tb/tb_fc_argmax.sv
// Directed self-checking bench for fc_argmax: argmax results, stalls, signed compare,
// malformed frames, abort, implicit start and reset.
module tb_fc_argmax;
  logic clk;
  logic rstn;
  int   n_checks;
  int   n_errors;

  fc_argmax_if #(.DATA_W(32), .IDX_W(4)) bus ();

  fc_argmax #(.NUM_CLASS(10), .DATA_W(32), .IDX_W(4)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one cycle; outputs are then sampled 1 time unit after the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [31:0] d);
    bus.result_tvalid = 1'b1;
    bus.result_tdata  = d;
    step();
    bus.result_tvalid = 1'b0;
  endtask

  task automatic pulse_start();
    bus.start_cnn = 1'b1;
    step();
    bus.start_cnn = 1'b0;
  endtask

  task automatic handshake();
    bus.class_tready = 1'b1;
    step();
    bus.class_tready = 1'b0;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    step();
    step();
    n_checks++;
    if (bus.class_tvalid !== 1'b0 || bus.class_tdata !== 4'd0 || bus.class_score !== 32'd0 ||
        bus.frame_err !== 1'b0 || bus.beat_cnt !== 4'd0) begin
      n_errors++;
      $display("FAIL reset: valid=%0b idx=%0d score=%0d err=%0b cnt=%0d, required 0 0 0 0 0",
               bus.class_tvalid, bus.class_tdata, bus.class_score, bus.frame_err, bus.beat_cnt);
    end
    rstn = 1'b1;
    step();
  endtask

  task automatic test_basic();
    int s[10] = '{-5, 3, 17, -2, 0, 9, 17, -100, 4, 1};
    pulse_start();
    n_checks++;
    if (bus.beat_cnt !== 4'd0) begin
      n_errors++; $display("FAIL basic_start_cnt: got %0d, required 0", bus.beat_cnt);
    end
    for (int i = 0; i < 10; i++) begin
      bus.cnn_done = (i == 9);
      beat(32'(s[i]));
      if (i == 8) begin
        n_checks++;
        if (bus.class_tvalid !== 1'b0) begin
          n_errors++; $display("FAIL basic_early_valid: got %0b, required 0", bus.class_tvalid);
        end
      end
    end
    bus.cnn_done = 1'b0;
    n_checks++;
    if (bus.class_tvalid !== 1'b1 || bus.class_tdata !== 4'd2 || $signed(bus.class_score) !== 32'sd17 ||
        bus.frame_err !== 1'b0 || bus.beat_cnt !== 4'd10) begin
      n_errors++;
      $display("FAIL basic_result: valid=%0b idx=%0d score=%0d err=%0b cnt=%0d, required 1 2 17 0 10",
               bus.class_tvalid, bus.class_tdata, $signed(bus.class_score), bus.frame_err, bus.beat_cnt);
    end
    handshake();
    n_checks++;
    if (bus.class_tvalid !== 1'b0 || bus.class_tdata !== 4'd2) begin
      n_errors++;
      $display("FAIL basic_handshake: valid=%0b idx=%0d, required 0 2", bus.class_tvalid, bus.class_tdata);
    end
  endtask

  task automatic test_stall();
    pulse_start();
    for (int i = 0; i < 10; i++) beat(32'(i - 10));
    for (int c = 0; c < 5; c++) begin
      n_checks++;
      if (bus.class_tvalid !== 1'b1 || bus.class_tdata !== 4'd9 || $signed(bus.class_score) !== -32'sd1) begin
        n_errors++;
        $display("FAIL stall_hold[%0d]: valid=%0b idx=%0d score=%0d, required 1 9 -1",
                 c, bus.class_tvalid, bus.class_tdata, $signed(bus.class_score));
      end
      step();
    end
    handshake();
    n_checks++;
    if (bus.class_tvalid !== 1'b0 || bus.class_tdata !== 4'd9 || $signed(bus.class_score) !== -32'sd1) begin
      n_errors++;
      $display("FAIL stall_release: valid=%0b idx=%0d score=%0d, required 0 9 -1",
               bus.class_tvalid, bus.class_tdata, $signed(bus.class_score));
    end
  endtask

  task automatic test_signed();
    pulse_start();
    for (int i = 0; i < 10; i++) begin
      if (i == 0)      beat(32'h8000_0000);
      else if (i == 3) beat(32'h7FFF_FFFF);
      else             beat(32'hFFFF_FFF9);
    end
    n_checks++;
    if (bus.class_tvalid !== 1'b1 || bus.class_tdata !== 4'd3 || bus.class_score !== 32'd2147483647) begin
      n_errors++;
      $display("FAIL signed_cmp: valid=%0b idx=%0d score=%0d, required 1 3 2147483647",
               bus.class_tvalid, bus.class_tdata, $signed(bus.class_score));
    end
    handshake();
  endtask

  task automatic test_short_frame();
    pulse_start();
    for (int i = 0; i < 6; i++) beat(32'(i + 1));
    bus.cnn_done = 1'b1;
    step();
    bus.cnn_done = 1'b0;
    n_checks++;
    if (bus.class_tvalid !== 1'b0 || bus.frame_err !== 1'b1 || bus.beat_cnt !== 4'd6) begin
      n_errors++;
      $display("FAIL short_flag: valid=%0b err=%0b cnt=%0d, required 0 1 6",
               bus.class_tvalid, bus.frame_err, bus.beat_cnt);
    end
    step(); step(); step();
    n_checks++;
    if (bus.class_tvalid !== 1'b0 || bus.frame_err !== 1'b1) begin
      n_errors++;
      $display("FAIL short_idle: valid=%0b err=%0b, required 0 1", bus.class_tvalid, bus.frame_err);
    end
    pulse_start();
    n_checks++;
    if (bus.frame_err !== 1'b0 || bus.beat_cnt !== 4'd0) begin
      n_errors++;
      $display("FAIL short_clear: err=%0b cnt=%0d, required 0 0", bus.frame_err, bus.beat_cnt);
    end
  endtask

  task automatic test_over_long();
    // Frame already started by the clearing start_cnn of the previous task
    for (int i = 0; i < 10; i++) beat(32'(i + 1));
    n_checks++;
    if (bus.class_tvalid !== 1'b1 || bus.frame_err !== 1'b0) begin
      n_errors++;
      $display("FAIL long_tenth: valid=%0b err=%0b, required 1 0", bus.class_tvalid, bus.frame_err);
    end
    beat(32'd100);
    n_checks++;
    if (bus.class_tvalid !== 1'b1 || bus.frame_err !== 1'b1 || bus.class_tdata !== 4'd9 ||
        $signed(bus.class_score) !== 32'sd10 || bus.beat_cnt !== 4'd10) begin
      n_errors++;
      $display("FAIL long_extra: valid=%0b err=%0b idx=%0d score=%0d cnt=%0d, required 1 1 9 10 10",
               bus.class_tvalid, bus.frame_err, bus.class_tdata, $signed(bus.class_score), bus.beat_cnt);
    end
    handshake();
    n_checks++;
    if (bus.class_tvalid !== 1'b0 || bus.frame_err !== 1'b1) begin
      n_errors++;
      $display("FAIL long_sticky: valid=%0b err=%0b, required 0 1", bus.class_tvalid, bus.frame_err);
    end
  endtask

  task automatic test_abort();
    int s[9] = '{2, 8, 1, 8, 0, 0, 0, 0, 7};
    pulse_start();
    for (int i = 0; i < 4; i++) beat(32'd500);
    bus.start_cnn     = 1'b1;
    bus.result_tvalid = 1'b1;
    bus.result_tdata  = 32'hFFFF_FFFD;
    step();
    bus.start_cnn     = 1'b0;
    bus.result_tvalid = 1'b0;
    n_checks++;
    if (bus.beat_cnt !== 4'd1 || bus.frame_err !== 1'b0 || bus.class_tvalid !== 1'b0) begin
      n_errors++;
      $display("FAIL abort_restart: cnt=%0d err=%0b valid=%0b, required 1 0 0",
               bus.beat_cnt, bus.frame_err, bus.class_tvalid);
    end
    for (int i = 0; i < 9; i++) beat(32'(s[i]));
    n_checks++;
    if (bus.class_tvalid !== 1'b1 || bus.class_tdata !== 4'd2 || $signed(bus.class_score) !== 32'sd8) begin
      n_errors++;
      $display("FAIL abort_result: valid=%0b idx=%0d score=%0d, required 1 2 8",
               bus.class_tvalid, bus.class_tdata, $signed(bus.class_score));
    end
    handshake();
  endtask

  task automatic test_implicit_and_reset();
    for (int i = 0; i < 10; i++) beat(32'h8000_0000);
    n_checks++;
    if (bus.class_tvalid !== 1'b1 || bus.class_tdata !== 4'd0 || bus.class_score !== 32'h8000_0000 ||
        bus.beat_cnt !== 4'd10) begin
      n_errors++;
      $display("FAIL implicit_min: valid=%0b idx=%0d score=%h cnt=%0d, required 1 0 80000000 10",
               bus.class_tvalid, bus.class_tdata, bus.class_score, bus.beat_cnt);
    end
    beat(32'd5);
    n_checks++;
    if (bus.frame_err !== 1'b1 || bus.class_score !== 32'h8000_0000) begin
      n_errors++;
      $display("FAIL out_extra: err=%0b score=%h, required 1 80000000", bus.frame_err, bus.class_score);
    end
    rstn = 1'b0;
    step();
    rstn = 1'b1;
    n_checks++;
    if (bus.class_tvalid !== 1'b0 || bus.class_tdata !== 4'd0 || bus.class_score !== 32'd0 ||
        bus.frame_err !== 1'b0 || bus.beat_cnt !== 4'd0) begin
      n_errors++;
      $display("FAIL reset_in_out: valid=%0b idx=%0d score=%0d err=%0b cnt=%0d, required 0 0 0 0 0",
               bus.class_tvalid, bus.class_tdata, bus.class_score, bus.frame_err, bus.beat_cnt);
    end
    step(); step();
    n_checks++;
    if (bus.class_tvalid !== 1'b0) begin
      n_errors++; $display("FAIL reset_no_output: valid=%0b, required 0", bus.class_tvalid);
    end
  endtask

  initial begin
    n_checks          = 0;
    n_errors          = 0;
    rstn              = 1'b0;
    bus.start_cnn     = 1'b0;
    bus.cnn_done      = 1'b0;
    bus.result_tvalid = 1'b0;
    bus.result_tdata  = 32'd0;
    bus.class_tready  = 1'b0;
    test_reset();
    test_basic();
    test_stall();
    test_signed();
    test_short_frame();
    test_over_long();
    test_abort();
    test_implicit_and_reset();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
